// File: rtl/chan_accum_if.sv
// Lane-parallel stream between spn and chan_accum, plus the accumulated frame going to write-back.
// The master modport is the upstream/observer side; the slave modport is the accumulator.
interface chan_accum_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned PARA       = 16
);
  logic [DATA_WIDTH-1:0] input_stream  [PARA];
  logic                  valid_in;
  logic [ACC_WIDTH-1:0]  output_stream [PARA];
  logic                  valid_out;
  logic                  out_last;

  modport master (
    output input_stream,
    output valid_in,
    input  output_stream,
    input  valid_out,
    input  out_last
  );

  modport slave (
    input  input_stream,
    input  valid_in,
    output output_stream,
    output valid_out,
    output out_last
  );
endinterface

// File: rtl/chan_accum.sv
// Sums NUM_CH consecutive FRAME_BEATS-beat frames lane-by-lane and emits the summed frame
// while the last channel arrives, one cycle after each of that channel's beats.
module chan_accum #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PARA        = 16,
  parameter int unsigned FRAME_BEATS = 16,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ACC_WIDTH   = 32
) (
  input  logic          clk,
  input  logic          rst,
  chan_accum_if.slave   bus
);

  localparam int unsigned BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(FRAME_BEATS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NUM_CH - 1);

  logic [BW-1:0]          b_q, b_d;
  logic [CW-1:0]          c_q, c_d;
  logic [ACC_WIDTH-1:0]   acc_q [FRAME_BEATS][PARA];
  logic [ACC_WIDTH-1:0]   sum_d [PARA];
  logic [ACC_WIDTH-1:0]   out_q [PARA];
  logic                   valid_q;
  logic                   last_q;
  logic signed [DATA_WIDTH-1:0] lane_in;
  logic                   first_ch;
  logic                   last_ch;
  logic                   last_beat;

  assign first_ch  = (c_q == '0);
  assign last_ch   = (c_q == C_LAST);
  assign last_beat = (b_q == B_LAST);

  // Channel 0 overwrites the buffer entry, later channels add onto it.
  always_comb begin
    lane_in = '0;
    for (int i = 0; i < PARA; i++) begin
      lane_in  = bus.input_stream[i];
      sum_d[i] = ACC_WIDTH'(lane_in);
      if (!first_ch) begin
        sum_d[i] = acc_q[b_q][i] + sum_d[i];
      end
    end
  end

  always_comb begin
    b_d = b_q;
    c_d = c_q;
    if (bus.valid_in) begin
      if (last_beat) begin
        b_d = '0;
        c_d = last_ch ? '0 : c_q + CW'(1);
      end else begin
        b_d = b_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < PARA; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      b_q     <= b_d;
      c_q     <= c_d;
      valid_q <= bus.valid_in && last_ch;
      last_q  <= bus.valid_in && last_ch && last_beat;
      if (bus.valid_in && last_ch) begin
        out_q <= sum_d;
      end
    end
  end

  // Buffer is deliberately left out of reset; channel 0 always overwrites before any read.
  always_ff @(posedge clk) begin
    if (bus.valid_in && !rst) begin
      acc_q[b_q] <= sum_d;
    end
  end

  assign bus.output_stream = out_q;
  assign bus.valid_out     = valid_q;
  assign bus.out_last      = last_q;

endmodule
